// File: rtl/fp8_pkg.sv
// Shared fp8 definitions: 1 sign, 3 exponent, 4 mantissa bits, bias 3,
// exponent field 000 is denormal with scale 2^-2.
package fp8_pkg;

  typedef logic [7:0] fp8_t;

  localparam int unsigned FP8_SIGN_BIT = 7;
  localparam int unsigned FP8_EXP_W    = 3;
  localparam int unsigned FP8_MAN_W    = 4;
  localparam int unsigned FP8_BIAS     = 3;
  localparam int unsigned FP8_MAG_W    = 11;   // magnitude in units of 2^-6

  localparam fp8_t                 FP8_ZERO     = 8'h00;
  localparam fp8_t                 FP8_NEG_ZERO = 8'h80;
  localparam logic [FP8_EXP_W-1:0] FP8_EXP_MAX  = 3'b111;

  typedef enum logic {
    ACC  = 1'b0,
    DONE = 1'b1
  } acc_state_t;

  // Unsigned magnitude as an integer count of 2^-6 (the denormal step).
  function automatic logic [FP8_MAG_W-1:0] fp8_mag(input fp8_t x);
    logic [FP8_EXP_W-1:0] e;
    logic [FP8_MAG_W-1:0] m;
    e = x[FP8_MAN_W +: FP8_EXP_W];
    if (e == '0) begin
      m = FP8_MAG_W'(x[FP8_MAN_W-1:0]);
    end else begin
      m = FP8_MAG_W'({1'b1, x[FP8_MAN_W-1:0]}) << (e - 3'd1);
    end
    return m;
  endfunction

endpackage

// File: rtl/fp8_acc_addr_top.sv
// addr_top: combinational fp8 adder.
//   in_a, in_b : fp8 operands
//   res        : fp8 sum, truncated toward zero; magnitudes beyond 31.0
//                clamp to the largest finite code. An exact cancellation
//                carries the sign of in_b, so it can return 8'h80.
module addr_top
  import fp8_pkg::*;
(
  input  fp8_t in_a,
  input  fp8_t in_b,
  output fp8_t res
);

  localparam int unsigned SUM_W = FP8_MAG_W + 2;

  logic signed [SUM_W-1:0] op_a;
  logic signed [SUM_W-1:0] op_b;
  logic signed [SUM_W-1:0] sum;
  logic [SUM_W-2:0]        mag_s;
  logic                    sign_r;
  logic [FP8_EXP_W-1:0]    exp_r;
  logic [FP8_MAN_W-1:0]    man_r;

  // Exact fixed-point add, then renormalise from the leading one.
  always_comb begin
    op_a = $signed({2'b00, fp8_mag(in_a)});
    op_b = $signed({2'b00, fp8_mag(in_b)});
    if (in_a[FP8_SIGN_BIT]) op_a = -op_a;
    if (in_b[FP8_SIGN_BIT]) op_b = -op_b;
    sum    = op_a + op_b;
    mag_s  = sum[SUM_W-1] ? (SUM_W-1)'(-sum) : (SUM_W-1)'(sum);
    sign_r = sum[SUM_W-1] | ((sum == '0) & in_b[FP8_SIGN_BIT]);
    exp_r  = '0;
    man_r  = mag_s[FP8_MAN_W-1:0];
    if (mag_s[SUM_W-2]) begin
      exp_r = FP8_EXP_MAX;
      man_r = '1;
    end else begin
      for (int p = FP8_MAN_W; p < SUM_W - 2; p++) begin
        if (mag_s[p]) begin
          exp_r = FP8_EXP_W'(p - (FP8_MAN_W - 1));
          man_r = FP8_MAN_W'(mag_s >> (p - FP8_MAN_W));
        end
      end
    end
    res = {sign_r, exp_r, man_r};
  end

endmodule

// File: rtl/fp8_acc.sv
// fp8_acc: streaming fp8 vector accumulator around a single addr_top.
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid/in_ready   : term handshake; in_data term, in_last closes vector
//   out_valid/out_ready : result handshake
//   out_data            : fp8 sum (negative zero folded to +0)
//   out_zero            : sum is zero
//   out_cnt             : number of terms in the sum
//   out_sat             : only with FP8_ACC_SAT_FLAG_EN; an intermediate sum
//                         reached exponent field 3'b111
module fp8_acc
  import fp8_pkg::*;
#(
  parameter int unsigned VEC_LEN = 8,
  parameter int unsigned CNT_W   = $clog2(VEC_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_zero,
  output logic [CNT_W-1:0] out_cnt
`ifdef FP8_ACC_SAT_FLAG_EN
  ,
  output logic             out_sat
`endif
);

  acc_state_t       state_q, state_d;
  fp8_t             acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  fp8_t             sum_raw, sum_norm;
  logic             accept, close;
  logic             in_ready_d, out_valid_d, out_zero_d;
  fp8_t             out_data_d;
  logic [CNT_W-1:0] out_cnt_d;
`ifdef FP8_ACC_SAT_FLAG_EN
  logic             sat_q, sat_d, sat_hit, out_sat_d;
`endif

  // Feedback adder: running sum on in_a, incoming term on in_b.
  addr_top u_addr (
    .in_a (acc_q),
    .in_b (in_data),
    .res  (sum_raw)
  );

  assign sum_norm = (sum_raw == FP8_NEG_ZERO) ? FP8_ZERO : sum_raw;
  assign accept   = in_valid & in_ready;
  assign cnt_inc  = cnt_q + CNT_W'(1);
  assign close    = accept & (in_last | (cnt_q == CNT_W'(VEC_LEN - 1)));
`ifdef FP8_ACC_SAT_FLAG_EN
  assign sat_hit  = (sum_norm[FP8_MAN_W +: FP8_EXP_W] == FP8_EXP_MAX);
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    out_data_d = out_data;
    out_zero_d = out_zero;
    out_cnt_d  = out_cnt;
`ifdef FP8_ACC_SAT_FLAG_EN
    sat_d      = sat_q;
    out_sat_d  = out_sat;
`endif
    case (state_q)
      ACC: begin
        if (accept) begin
          acc_d = sum_norm;
          cnt_d = cnt_inc;
`ifdef FP8_ACC_SAT_FLAG_EN
          sat_d = sat_q | sat_hit;
`endif
          if (close) begin
            state_d    = DONE;
            out_data_d = sum_norm;
            out_zero_d = (sum_norm == FP8_ZERO);
            out_cnt_d  = cnt_inc;
`ifdef FP8_ACC_SAT_FLAG_EN
            out_sat_d  = sat_q | sat_hit;
`endif
          end
        end
      end
      DONE: begin
        if (out_valid & out_ready) begin
          state_d = ACC;
          acc_d   = FP8_ZERO;
          cnt_d   = '0;
`ifdef FP8_ACC_SAT_FLAG_EN
          sat_d     = 1'b0;
          out_sat_d = 1'b0;
`endif
        end
      end
      default: state_d = ACC;
    endcase
    in_ready_d  = (state_d == ACC);
    out_valid_d = (state_d == DONE);
  end

  // State and output registers; in_ready stays low through the reset cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ACC;
      acc_q     <= FP8_ZERO;
      cnt_q     <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= FP8_ZERO;
      out_zero  <= 1'b0;
      out_cnt   <= '0;
`ifdef FP8_ACC_SAT_FLAG_EN
      sat_q     <= 1'b0;
      out_sat   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      out_data  <= out_data_d;
      out_zero  <= out_zero_d;
      out_cnt   <= out_cnt_d;
`ifdef FP8_ACC_SAT_FLAG_EN
      sat_q     <= sat_d;
      out_sat   <= out_sat_d;
`endif
    end
  end

endmodule

// File: tb/tb_fp8_acc.sv
// Bench for fp8_acc with VEC_LEN=3. A real-valued model (decode, add,
// truncate toward zero) is compared against the DUT every cycle, plus
// hand-computed expectations per directed vector.
// Define FP8_ACC_SAT_FLAG_EN to exercise out_sat as well.
module tb_fp8_acc;

  localparam int unsigned VL = 3;
  localparam int unsigned CW = 2;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    out_data;
  logic          out_zero;
  logic [CW-1:0] out_cnt;
`ifdef FP8_ACC_SAT_FLAG_EN
  logic          out_sat;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  // Model state
  bit         m_known = 0;
  bit         m_ir, m_ov, m_zero, m_sat, m_hit;
  logic [7:0] m_acc, m_data;
  int         m_cnt, m_ocnt;

  fp8_acc #(.VEC_LEN(VL), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_zero  (out_zero),
    .out_cnt   (out_cnt)
`ifdef FP8_ACC_SAT_FLAG_EN
    ,
    .out_sat   (out_sat)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Real value of an fp8 code.
  function automatic real dec(input logic [7:0] c);
    int  e;
    int  m;
    real v;
    real sc;
    e = int'(c[6:4]);
    m = int'(c[3:0]);
    if (e == 0) begin
      v = (m / 16.0) * 0.25;
    end else begin
      sc = 0.125;
      for (int k = 0; k < e; k++) sc = sc * 2.0;
      v = (1.0 + m / 16.0) * sc;
    end
    return c[7] ? -v : v;
  endfunction

  // Largest-magnitude code not exceeding |x|, with x's sign; zero is +0.
  function automatic logic [7:0] enc(input real x);
    real        a;
    logic [7:0] best;
    a    = (x < 0.0) ? -x : x;
    best = 8'h00;
    for (int c = 0; c < 128; c++) begin
      if (dec(8'(c)) <= a) best = 8'(c);
    end
    if (best == 8'h00) return 8'h00;
    return {(x < 0.0), best[6:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    real v;
    if (!rst_n) begin
      m_known = 1; m_ir = 0; m_ov = 0; m_acc = 8'h00; m_cnt = 0;
      m_data = 8'h00; m_zero = 0; m_ocnt = 0; m_hit = 0; m_sat = 0;
    end else if (m_known) begin
      if (!m_ov) begin
        if (in_valid && m_ir) begin
          m_acc = enc(dec(m_acc) + dec(in_data));
          m_cnt++;
          v = dec(m_acc);
          if (v >= 16.0 || v <= -16.0) m_hit = 1;
          if (in_last || m_cnt == int'(VL)) begin
            m_ov = 1; m_data = m_acc; m_zero = (dec(m_acc) == 0.0);
            m_ocnt = m_cnt; m_sat = m_hit;
          end
        end
      end else if (out_ready) begin
        m_ov = 0; m_acc = 8'h00; m_cnt = 0; m_hit = 0; m_sat = 0;
      end
      m_ir = !m_ov;
    end
  endtask

  task automatic compare();
    if (!m_known) return;
    chk("in_ready", 32'(in_ready), 32'(m_ir));
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    if (m_ov) begin
      chk("out_data", 32'(out_data), 32'(m_data));
      chk("out_zero", 32'(out_zero), 32'(m_zero));
      chk("out_cnt", 32'(out_cnt), 32'(m_ocnt));
`ifdef FP8_ACC_SAT_FLAG_EN
      chk("out_sat", 32'(out_sat), 32'(m_sat));
`endif
    end
  endtask

  // One clock: compare on the falling edge, advance the model on the rising edge.
  task automatic cyc();
    @(negedge clk);
    compare();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic term(input logic [7:0] d, input logic last);
    in_valid = 1'b1; in_data = d; in_last = last;
    cyc();
    in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
  endtask

  task automatic wait_out();
    int n;
    n = 0;
    while (!out_valid && n < 10) begin
      cyc();
      n++;
    end
    chk("wait_out_valid", 32'(out_valid), 32'd1);
  endtask

  task automatic expect_sum(input string name, input logic [7:0] d, input logic z, input int c);
    chk({name, "_data"}, 32'(out_data), 32'(d));
    chk({name, "_zero"}, 32'(out_zero), 32'(z));
    chk({name, "_cnt"},  32'(out_cnt),  32'(c));
  endtask

  task automatic take();
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; out_ready = 1'b0;
    cyc();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    expect_sum("rst", 8'h00, 1'b0, 0);
    rst_n = 1'b1;
    cyc();
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Back-to-back, auto-close at VEC_LEN
    out_ready = 1'b1;
    term(8'h15, 1'b0);
    term(8'h0A, 1'b0);
    chk("t1_not_yet", 32'(out_valid), 32'd0);
    term(8'h0A, 1'b0);
    chk("t1_latency", 32'(out_valid), 32'd1);
    expect_sum("t1", 8'h24, 1'b0, 3);
    cyc();
    out_ready = 1'b0;
    chk("t1_ready_again", 32'(in_ready), 32'd1);

    // Cancellation to zero, both operand orders of sign
    term(8'h1F, 1'b0); term(8'h9F, 1'b1); wait_out();
    expect_sum("t2a", 8'h00, 1'b1, 2); take();
    term(8'h24, 1'b0); term(8'hA4, 1'b1); wait_out();
    expect_sum("t2b", 8'h00, 1'b1, 2); take();

    // Signed result and single-term vector
    term(8'h1F, 1'b0); term(8'hA4, 1'b1); wait_out();
    expect_sum("t3a", 8'h89, 1'b0, 2); take();
    term(8'h1F, 1'b1); wait_out();
    expect_sum("t3b", 8'h1F, 1'b0, 1); take();

    // Back-pressure; the in_valid pulse must be ignored
    term(8'h15, 1'b1); wait_out();
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        in_valid = 1'b1; in_data = 8'h0A; in_last = 1'b1;
      end
      cyc();
      in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
      chk("t4_hold_valid", 32'(out_valid), 32'd1);
      chk("t4_hold_ready", 32'(in_ready), 32'd0);
      expect_sum("t4_hold", 8'h15, 1'b0, 1);
    end
    take();
    chk("t4_ready_after", 32'(in_ready), 32'd1);
    term(8'h0A, 1'b1); wait_out();
    expect_sum("t4_next", 8'h0A, 1'b0, 1); take();

    // Reset mid-vector
    term(8'h15, 1'b0); term(8'h0A, 1'b0);
    rst_n = 1'b0;
    cyc();
    chk("t5_rst_valid", 32'(out_valid), 32'd0);
    chk("t5_rst_ready", 32'(in_ready), 32'd0);
    expect_sum("t5_rst", 8'h00, 1'b0, 0);
    rst_n = 1'b1;
    cyc();
    chk("t5_ready", 32'(in_ready), 32'd1);
    term(8'h0A, 1'b1); wait_out();
    expect_sum("t5_after", 8'h0A, 1'b0, 1); take();

    // Overflow clamps, negative zero input, negative overflow
    term(8'h7F, 1'b0); term(8'h7F, 1'b0); term(8'h7F, 1'b0); wait_out();
    expect_sum("ovf", 8'h7F, 1'b0, 3); take();
    term(8'h80, 1'b1); wait_out();
    expect_sum("negz", 8'h00, 1'b1, 1); take();
    term(8'hFF, 1'b0); term(8'hFF, 1'b1); wait_out();
    expect_sum("novf", 8'hFF, 1'b0, 2); take();

`ifdef FP8_ACC_SAT_FLAG_EN
    term(8'h7F, 1'b0); term(8'h00, 1'b1); wait_out();
    chk("t6_sat_set", 32'(out_sat), 32'd1);
    expect_sum("t6a", 8'h7F, 1'b0, 2); take();
    chk("t6_sat_clr", 32'(out_sat), 32'd0);
    term(8'h15, 1'b1); wait_out();
    chk("t6_sat_low", 32'(out_sat), 32'd0);
    expect_sum("t6b", 8'h15, 1'b0, 1); take();
`endif

    cyc(); cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
